// File: rtl/fwd_mux_stage_reg_pkg.sv
// fwd_mux_stage_reg_pkg: shared stall-counter default width and select-width helper
package fwd_mux_stage_reg_pkg;
  localparam int STALL_CNT_W = 8;
  function automatic int selWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fwd_mux_stage_reg_mux.sv
// multiplexer_nto1: combinational N:1 word selector with out-of-range flag
module multiplexer_nto1
  import fwd_mux_stage_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NUM_IN = 4,
  localparam int SEL_W = selWidth(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        selData,
  output logic                    sel_out_of_range
);
  // pick the matching source; unmatched select values fall through to zero
  always_comb begin
    selData = '0;
    for (int k = 0; k < NUM_IN; k++) if (sel == SEL_W'(k)) selData = in_data[k*WIDTH +: WIDTH];
  end
  assign sel_out_of_range = 32'(sel) >= 32'(NUM_IN);
endmodule

// File: rtl/fwd_mux_stage_reg.sv
// fwd_mux_stage_reg: N:1 operand selector registered into the next pipeline stage
module fwd_mux_stage_reg
  import fwd_mux_stage_reg_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NUM_IN = 4,
  parameter int CNT_W = STALL_CNT_W,
  localparam int SEL_W = selWidth(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    stall,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    sel_err,
  output logic [CNT_W-1:0]        stall_cnt
);
  logic [WIDTH-1:0] selData;
  logic             selBad;
  multiplexer_nto1 #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) uMux (
    .in_data(in_data),
    .sel(sel),
    .selData(selData),
    .sel_out_of_range(selBad)
  );
  // stage register: flush beats stall beats load; out_sel survives a flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sel   <= '0;
      sel_err   <= 1'b0;
    end else if (flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else if (!stall) begin
      out_data  <= selData;
      out_valid <= in_valid & ~selBad;
      out_sel   <= sel;
      sel_err   <= selBad;
    end
  end
  // consecutive-stall counter, saturating, unaffected by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else stall_cnt <= !stall ? '0 : (&stall_cnt ? stall_cnt : stall_cnt + CNT_W'(1));
  end
endmodule

// File: tb/tb_fwd_mux_stage_reg.sv
// tb_fwd_mux_stage_reg: scoreboard bench for a 4-input/8-bit-count and a 3-input/3-bit-count stage
module tb_fwd_mux_stage_reg;
  typedef struct {
    int          due;
    bit          b;
    logic [15:0] d;
    logic        v;
    logic [1:0]  s;
    logic        e;
    logic [7:0]  c;
  } exp_t;

  localparam logic [63:0] SRC = 64'h4444_3333_2222_1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] inData;
  logic        inValid, stall, flush;
  logic [1:0]  sel;
  logic [15:0] aData, bData;
  logic        aValid, bValid, aErr, bErr;
  logic [1:0]  aSel, bSel;
  logic [7:0]  aCnt;
  logic [2:0]  bCnt;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];

  fwd_mux_stage_reg #(.WIDTH(16), .NUM_IN(4), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .in_data(inData), .in_valid(inValid), .sel(sel),
    .stall(stall), .flush(flush), .out_data(aData), .out_valid(aValid),
    .out_sel(aSel), .sel_err(aErr), .stall_cnt(aCnt)
  );

  fwd_mux_stage_reg #(.WIDTH(16), .NUM_IN(3), .CNT_W(3)) dutB (
    .clk(clk), .rst_n(rst_n), .in_data(inData[47:0]), .in_valid(inValid), .sel(sel),
    .stall(stall), .flush(flush), .out_data(bData), .out_valid(bValid),
    .out_sel(bSel), .sel_err(bErr), .stall_cnt(bCnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input exp_t x, input string tag);
    logic [27:0] act, req;
    act = x.b ? {bData, bValid, bSel, bErr, 5'd0, bCnt} : {aData, aValid, aSel, aErr, aCnt};
    req = {x.d, x.v, x.s, x.e, x.c};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%s data/valid/sel/err/cnt got %h/%b/%0d/%b/%0d want %h/%b/%0d/%b/%0d",
               tag, x.b ? "B" : "A", act[27:12], act[11], act[10:9], act[8], act[7:0],
               x.d, x.v, x.s, x.e, x.c);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].due <= cyc) check(sb.pop_front(), "sb");
  end

  task automatic push(input bit b, input logic [15:0] d, input logic v, input logic [1:0] os,
                      input logic e, input logic [7:0] c);
    sb.push_back('{cyc + 1, b, d, v, os, e, c});
  endtask

  task automatic step(input logic [1:0] s, input logic iv, input logic st, input logic fl,
                      input bit b, input logic [15:0] d, input logic v, input logic [1:0] os,
                      input logic e, input logic [7:0] c);
    @(posedge clk);
    #1;
    sel = s;
    inValid = iv;
    stall = st;
    flush = fl;
    push(b, d, v, os, e, c);
  endtask

  initial begin
    rst_n = 1'b0;
    inData = SRC;
    inValid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    check('{0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 8'd0}, "reset_hold_A");
    check('{0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b0, 8'd0}, "reset_hold_B");
    rst_n = 1'b1;
    step(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd0, 1'b0, 8'd0);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 2'd1, 1'b0, 8'd0);
    step(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 16'h2222, 1'b1, 2'd1, 1'b0, 8'd1);
    @(posedge clk);
    #6;
    rst_n = 1'b0;
    #1;
    check('{0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 8'd0}, "async_reset_A");
    check('{0, 1'b1, 16'h0, 1'b0, 2'd0, 1'b0, 8'd0}, "async_reset_B");
    @(posedge clk);
    #1;
    check('{0, 1'b0, 16'h0, 1'b0, 2'd0, 1'b0, 8'd0}, "reset_beats_stall");
    stall = 1'b0;
    flush = 1'b1;
    rst_n = 1'b1;
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b1, 2'd0, 1'b0, 8'd0);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 2'd1, 1'b0, 8'd0);
    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b1, 2'd2, 1'b0, 8'd0);
    step(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4444, 1'b1, 2'd3, 1'b0, 8'd0);
    step(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b0, 2'd2, 1'b0, 8'd0);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2222, 1'b1, 2'd1, 1'b0, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      step(2'(k), 1'b0, 1'b1, 1'b0, 1'b0, 16'h2222, 1'b1, 2'd1, 1'b0, 8'(k));
      inData = (k == 5) ? SRC : 64'hDEAD_BEEF_CAFE_F00D ^ 64'(k);
    end
    step(2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 16'h4444, 1'b1, 2'd3, 1'b0, 8'd0);
    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3333, 1'b1, 2'd2, 1'b0, 8'd0);
    step(2'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'd2, 1'b0, 8'd1);
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1111, 1'b1, 2'd0, 1'b0, 8'd0);
    step(2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 2'd3, 1'b1, 8'd0);
    step(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 2'd3, 1'b1, 8'd1);
    step(2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 2'd3, 1'b0, 8'd0);
    step(2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 2'd3, 1'b1, 8'd0);
    step(2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'h2222, 1'b1, 2'd1, 1'b0, 8'd0);
    step(2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b1, 2'd0, 1'b0, 8'd0);
    for (int k = 1; k <= 10; k++) begin
      step(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1111, 1'b1, 2'd0, 1'b0, 8'((k > 7) ? 7 : k));
      push(1'b0, 16'h1111, 1'b1, 2'd0, 1'b0, 8'(k));
    end
    step(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 16'h3333, 1'b1, 2'd2, 1'b0, 8'd0);
    repeat (3) @(posedge clk);
    #6;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
